id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised instruction-decode stage for the pipelined GCD CPU, sitting between the fetch/IR register and the execute stage. It:
- decodes the MIPS subset into execute-stage controls;
- owns a write-first register file with register 0 hardwired to zero;
- stalls on load-use hazards and accepts a flush;
- moves data through a valid/ready handshake in place of free-running capture.

The jal link write goes down the pipeline as a normal write-back to r31; there is no decode-side write.

## Interface
Parameters:
- XLEN, 32, datapath and register width
- NREG, 32, architectural registers (16 or 32); index ≥ NREG reads 0, writes ignored
- SP_IDX, 29, stack-pointer register index
- SP_INIT, 508, stack-pointer reset value

Ports:
- clk  in  1  clock; one clock domain, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IR/PC valid from fetch
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  PC of instruction (already +4)
- in_ir  in  32  instruction word
- flush  in  1  kill held and incoming instruction (taken branch/jump)
- wb_we  in  1  write-back enable
- wb_rd  in  5  write-back index
- wb_data  in  XLEN  write-back data (mux done upstream)
- ex_memread  in  1  instruction in EX is a load
- ex_rd  in  5  destination of instruction in EX
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_memtoreg, out_regwrite, out_memread, out_memwrite  out  1 each  control flags
- out_branch, out_jump, out_jal, out_jr, out_illegal  out  1 each  instruction class flags
- out_aluctr  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 mul, 6 compare
- out_a, out_b, out_md  out  XLEN  rs value, operand B, rt store data
- out_imm  out  16  raw immediate
- out_rd  out  5  destination index
- out_pc  out  XLEN  instruction PC
- out_jt  out  XLEN  jump target
- dbg_addr  in  5  debug read index
- dbg_data  out  XLEN  combinational register read

## Operation
Decoding:
- R-type (op 0): B = rt value. funct 32/34/36/37/42/1 gives ALU codes 0/1/2/3/4/5. funct 8 (jr) gives regwrite 0, jr 1, jt = rs value. Any other funct gives illegal 1, treated as nop.
- addi (8): B = sign-extended immediate, regwrite 1, rd = rt.
- lw (35): B = sign-extended immediate, memread 1, memtoreg 1, regwrite 1, rd = rt.
- sw (43): B = sign-extended immediate, memwrite 1, md = rt value.
- beq (4): B = rt value, branch 1, aluctr 6.
- j (2): jump 1, jt = {pc[31:28], ir[25:0], 2'b00}.
- jal (3): as j, plus jal 1, regwrite 1, rd = 31, A = in_pc, B = 0, aluctr 0. Execute produces the link value, which write-back stores.
- Other opcodes: illegal 1, all write/memory controls 0.
- rd for R-type other than jr is ir[15:11].

Register file:
- 2 read ports (rs, rt) plus the debug port; 1 write port.
- Write-first: a read whose index equals wb_rd while wb_we=1 returns wb_data in the same cycle.
- r0 always reads 0; writes to r0 are dropped.

Hazard:
- `stall = ex_memread && ex_rd≠0 && (ex_rd==rs || (ex_rd==rt && op uses rt))`.
- rt is used by R-type, beq and sw.

Handshake:
- `in_ready = (!out_valid || out_ready) && !stall`.
- A transfer happens on in_valid && in_ready.
- While out_valid && !out_ready, all out_* hold stable.

Flush:
- Next cycle out_valid = 0. The incoming instruction is not captured, even if transferring. Flush has priority over load and stall.
- Register-file writes continue during flush and stall.

## Timing
- Latency: one cycle from transfer to out_valid.
- Throughput: one instruction per cycle with no stall.
- Load-use costs exactly one bubble: the next cycle out_valid = 0 unless the held bundle is still unaccepted.
- Reset effects (rst=1 at edge):
  - out_valid and all control/class flags go to 0.
  - aluctr, imm, rd, a, b, md, pc and jt go to 0.
  - All registers clear to 0, except REG[SP_IDX] = SP_INIT.
- Reset mid-operation drops the held bundle. A write-back in the same cycle as reset is discarded.
- A write-back in the same cycle as decode of a dependent instruction is seen by that decode (bypass).

## Structure
- Package id_pkg holds:
  - opcode/funct localparams;
  - the aluctr enum;
  - a packed ctrl_t struct (memtoreg, regwrite, memread, memwrite, branch, jump, jal, jr, illegal, aluctr).
- Sub-module id_regfile contains the register array, the write-first bypass, r0 masking, SP reset and the debug port.
- Decode logic and the output register stay in id_stage_pipe.

## Test plan
- Reset, then dbg_addr=29 → dbg_data=508; dbg_addr=5 → 0; out_valid=0.
- wb_we=1, wb_rd=8, wb_data=7 in the same cycle as decoding `add $9,$8,$1` (r1=1) → next cycle out_a=7, out_b=1, aluctr=0, rd=9.
- lw with ex_rd=8 and ex_memread=1, while decoding `sub $3,$8,$2` → in_ready=0 for one cycle, then out_valid with aluctr=1.
- out_ready=0 for 3 cycles with a bundle held → out_* unchanged, in_ready=0. Releasing out_ready → next instruction appears one cycle later.
- jal 0x40 at in_pc=0x104 → out_jal=1, rd=31, out_jt=0x100, out_a=0x104. jr with r31=0x104 → out_jr=1, out_jt=0x104.
- flush asserted during a transfer of addi → out_valid=0 next cycle. wb_rd=0 with wb_data=5 → r0 still reads 0. Opcode 63 → out_illegal=1, regwrite=0.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the GCD CPU decode stage: opcodes, functs,
// ALU control codes and the packed control bundle handed to execute.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_MUL = 6'd1;
  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5,
    ALU_CMP = 3'd6
  } aluctr_e;

  typedef struct packed {
    logic    memtoreg;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
    logic    jump;
    logic    jal;
    logic    jr;
    logic    illegal;
    aluctr_e aluctr;
  } ctrl_t;

  // Only these classes actually consume rt, so only they can hit a load-use on rt.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Bundles the fetch, write-back, EX-hazard, execute and debug signals of the
// decode stage; the stage itself uses the slave side.
interface id_stage_pipe_if #(parameter int XLEN = 32);
  import id_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_ir;
  logic            flush;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            ex_memread;
  logic [4:0]      ex_rd;
  logic            out_valid;
  logic            out_ready;
  logic            out_memtoreg;
  logic            out_regwrite;
  logic            out_memread;
  logic            out_memwrite;
  logic            out_branch;
  logic            out_jump;
  logic            out_jal;
  logic            out_jr;
  logic            out_illegal;
  aluctr_e         out_aluctr;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [XLEN-1:0] out_md;
  logic [15:0]     out_imm;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_jt;
  logic [4:0]      dbg_addr;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output in_valid, in_pc, in_ir, flush, wb_we, wb_rd, wb_data,
           ex_memread, ex_rd, out_ready, dbg_addr,
    input  in_ready, out_valid, out_memtoreg, out_regwrite, out_memread,
           out_memwrite, out_branch, out_jump, out_jal, out_jr, out_illegal,
           out_aluctr, out_a, out_b, out_md, out_imm, out_rd, out_pc, out_jt,
           dbg_data
  );

  modport slave (
    input  in_valid, in_pc, in_ir, flush, wb_we, wb_rd, wb_data,
           ex_memread, ex_rd, out_ready, dbg_addr,
    output in_ready, out_valid, out_memtoreg, out_regwrite, out_memread,
           out_memwrite, out_branch, out_jump, out_jal, out_jr, out_illegal,
           out_aluctr, out_a, out_b, out_md, out_imm, out_rd, out_pc, out_jt,
           dbg_data
  );

endinterface

// File: rtl/id_stage_pipe_regfile.sv
// Write-first register file: r0 reads zero, out-of-range indexes read zero and
// are never written, and the stack pointer comes out of reset preloaded.
module id_regfile #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 508
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] dbg_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic            write_en;

  function automatic logic in_range(input logic [4:0] idx);
    return 6'(idx) < 6'(NREG);
  endfunction

  // A write landing during reset is discarded, so it must not bypass either.
  assign write_en = wb_we && !rst && (wb_rd != 5'd0) && in_range(wb_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
    end else if (write_en) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  assign rs_data  = ((rs_addr == 5'd0) || !in_range(rs_addr)) ? '0 :
                    (write_en && (wb_rd == rs_addr)) ? wb_data : regs[rs_addr[AW-1:0]];
  assign rt_data  = ((rt_addr == 5'd0) || !in_range(rt_addr)) ? '0 :
                    (write_en && (wb_rd == rt_addr)) ? wb_data : regs[rt_addr[AW-1:0]];
  assign dbg_data = ((dbg_addr == 5'd0) || !in_range(dbg_addr)) ? '0 :
                    (write_en && (wb_rd == dbg_addr)) ? wb_data : regs[dbg_addr[AW-1:0]];

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage of the pipelined GCD CPU: decodes the MIPS subset, reads the
// register file, detects load-use hazards and registers the bundle for execute.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 508
) (
  input logic          clk,
  input logic          rst,
  id_stage_pipe_if.slave bus
);

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] rs_val, rt_val, sext, jtarget;
  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_a, dec_b, dec_jt;
  logic [4:0]      dec_rd;
  logic            stall, transfer;

  ctrl_t           ctrl_q;
  logic            valid_q;
  logic [XLEN-1:0] a_q, b_q, md_q, pc_q, jt_q;
  logic [15:0]     imm_q;
  logic [4:0]      rd_q;

  assign op      = bus.in_ir[31:26];
  assign rs      = bus.in_ir[25:21];
  assign rt      = bus.in_ir[20:16];
  assign rd      = bus.in_ir[15:11];
  assign funct   = bus.in_ir[5:0];
  assign sext    = {{(XLEN-16){bus.in_ir[15]}}, bus.in_ir[15:0]};
  assign jtarget = {bus.in_pc[XLEN-1:28], bus.in_ir[25:0], 2'b00};

  id_regfile #(
    .XLEN(XLEN), .NREG(NREG), .SP_IDX(SP_IDX), .SP_INIT(SP_INIT)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs),
    .rt_addr  (rt),
    .dbg_addr (bus.dbg_addr),
    .rs_data  (rs_val),
    .rt_data  (rt_val),
    .dbg_data (bus.dbg_data),
    .wb_we    (bus.wb_we),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data)
  );

  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.aluctr = ALU_ADD;
    dec_a           = rs_val;
    dec_b           = rt_val;
    dec_jt          = '0;
    dec_rd          = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_ctrl.aluctr = ALU_ADD;
          FN_SUB:  dec_ctrl.aluctr = ALU_SUB;
          FN_AND:  dec_ctrl.aluctr = ALU_AND;
          FN_OR:   dec_ctrl.aluctr = ALU_OR;
          FN_SLT:  dec_ctrl.aluctr = ALU_SLT;
          FN_MUL:  dec_ctrl.aluctr = ALU_MUL;
          FN_JR: begin
            dec_ctrl.jr = 1'b1;
            dec_jt      = rs_val;
          end
          default: dec_ctrl.illegal = 1'b1;
        endcase
        if (!dec_ctrl.jr && !dec_ctrl.illegal) begin
          dec_ctrl.regwrite = 1'b1;
          dec_rd            = rd;
        end
      end
      OP_ADDI: begin
        dec_b             = sext;
        dec_ctrl.regwrite = 1'b1;
        dec_rd            = rt;
      end
      OP_LW: begin
        dec_b             = sext;
        dec_ctrl.memread  = 1'b1;
        dec_ctrl.memtoreg = 1'b1;
        dec_ctrl.regwrite = 1'b1;
        dec_rd            = rt;
      end
      OP_SW: begin
        dec_b             = sext;
        dec_ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.aluctr = ALU_CMP;
      end
      OP_J: begin
        dec_ctrl.jump = 1'b1;
        dec_jt        = jtarget;
      end
      // Execute computes the link as pc+0, write-back stores it to r31.
      OP_JAL: begin
        dec_ctrl.jump     = 1'b1;
        dec_ctrl.jal      = 1'b1;
        dec_ctrl.regwrite = 1'b1;
        dec_rd            = 5'd31;
        dec_a             = bus.in_pc;
        dec_b             = '0;
        dec_jt            = jtarget;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  assign stall = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                 ((bus.ex_rd == rs) || ((bus.ex_rd == rt) && uses_rt(op)));
  assign bus.in_ready = (!valid_q || bus.out_ready) && !stall;
  assign transfer     = bus.in_valid && bus.in_ready;

  // Flush outranks capture; an unaccepted bundle otherwise holds all fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      md_q    <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      jt_q    <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (transfer) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      a_q     <= dec_a;
      b_q     <= dec_b;
      md_q    <= rt_val;
      imm_q   <= bus.in_ir[15:0];
      rd_q    <= dec_rd;
      pc_q    <= bus.in_pc;
      jt_q    <= dec_jt;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_memtoreg = ctrl_q.memtoreg;
  assign bus.out_regwrite = ctrl_q.regwrite;
  assign bus.out_memread  = ctrl_q.memread;
  assign bus.out_memwrite = ctrl_q.memwrite;
  assign bus.out_branch   = ctrl_q.branch;
  assign bus.out_jump     = ctrl_q.jump;
  assign bus.out_jal      = ctrl_q.jal;
  assign bus.out_jr       = ctrl_q.jr;
  assign bus.out_illegal  = ctrl_q.illegal;
  assign bus.out_aluctr   = ctrl_q.aluctr;
  assign bus.out_a        = a_q;
  assign bus.out_b        = b_q;
  assign bus.out_md       = md_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_jt       = jt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios then random traffic, all checked
// against an instruction-level reference model of the decode stage.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32)) bus ();

  id_stage_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [8:0]  flags;
    logic [2:0]  alu;
    logic [31:0] a, b, md, jt, pc;
    logic [15:0] imm;
    logic [4:0]  rd;
  } bundle_t;

  logic [31:0] mdl_regs [32];
  bundle_t     mdl_out;
  logic        mdl_valid;
  int          checks = 0;
  int          failures = 0;
  logic        last_ready;
  logic [31:0] last_dbg;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%h expected=0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  // Architectural register read as decode should see it, write-back included.
  function automatic logic [31:0] mdl_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (!rst && bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
    return mdl_regs[idx];
  endfunction

  function automatic bundle_t mdl_decode(input logic [31:0] ir, input logic [31:0] pc);
    bundle_t     r;
    logic [5:0]  op;
    logic [31:0] rsv, rtv, sext, jtgt;
    logic        mtr, rw, mr, mw, br, jp, jl, jrf, ill;
    op  = ir[31:26];
    mtr = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0;
    jp  = 1'b0; jl = 1'b0; jrf = 1'b0; ill = 1'b0;
    rsv  = mdl_read(ir[25:21]);
    rtv  = mdl_read(ir[20:16]);
    sext = {{16{ir[15]}}, ir[15:0]};
    jtgt = {pc[31:28], ir[25:0], 2'b00};
    r.a = rsv; r.b = rtv; r.md = rtv; r.jt = 32'd0; r.rd = 5'd0;
    r.alu = 3'd0; r.imm = ir[15:0]; r.pc = pc;
    case (op)
      6'd0: begin
        case (ir[5:0])
          6'd32: begin rw = 1'b1; r.alu = 3'd0; end
          6'd34: begin rw = 1'b1; r.alu = 3'd1; end
          6'd36: begin rw = 1'b1; r.alu = 3'd2; end
          6'd37: begin rw = 1'b1; r.alu = 3'd3; end
          6'd42: begin rw = 1'b1; r.alu = 3'd4; end
          6'd1:  begin rw = 1'b1; r.alu = 3'd5; end
          6'd8:  begin jrf = 1'b1; r.jt = rsv; end
          default: ill = 1'b1;
        endcase
        if (rw) r.rd = ir[15:11];
      end
      6'd8:  begin r.b = sext; rw = 1'b1; r.rd = ir[20:16]; end
      6'd35: begin r.b = sext; mr = 1'b1; mtr = 1'b1; rw = 1'b1; r.rd = ir[20:16]; end
      6'd43: begin r.b = sext; mw = 1'b1; end
      6'd4:  begin br = 1'b1; r.alu = 3'd6; end
      6'd2:  begin jp = 1'b1; r.jt = jtgt; end
      6'd3:  begin
        jp = 1'b1; jl = 1'b1; rw = 1'b1; r.rd = 5'd31;
        r.a = pc; r.b = 32'd0; r.jt = jtgt;
      end
      default: ill = 1'b1;
    endcase
    r.flags = {mtr, rw, mr, mw, br, jp, jl, jrf, ill};
    return r;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_regs[29] = 32'd508;
    mdl_valid = 1'b0;
    mdl_out = '{default: '0};
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_pc = 32'd0; bus.in_ir = 32'd0; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.ex_memread = 1'b0; bus.ex_rd = 5'd0; bus.out_ready = 1'b1; bus.dbg_addr = 5'd0;
  endtask

  // One clock with the inputs currently driven: check combinational outputs,
  // advance the model, then check the registered bundle after the edge.
  task automatic applyStimulus();
    bundle_t    nxt;
    logic       stall_e, ready_e, uses_rt;
    logic [5:0] op;
    #1;
    op      = bus.in_ir[31:26];
    uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd43);
    stall_e = bus.ex_memread && (bus.ex_rd != 5'd0) &&
              ((bus.ex_rd == bus.in_ir[25:21]) || ((bus.ex_rd == bus.in_ir[20:16]) && uses_rt));
    ready_e = (!mdl_valid || bus.out_ready) && !stall_e;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(ready_e));
    checkOutput("dbg_data", bus.dbg_data, mdl_read(bus.dbg_addr));
    last_ready = bus.in_ready;
    last_dbg   = bus.dbg_data;
    nxt = mdl_decode(bus.in_ir, bus.in_pc);
    if (rst) begin
      mdl_reset();
    end else begin
      if (bus.flush) mdl_valid = 1'b0;
      else if (bus.in_valid && ready_e) begin
        mdl_valid = 1'b1;
        mdl_out   = nxt;
      end else if (bus.out_ready) mdl_valid = 1'b0;
      if (bus.wb_we && bus.wb_rd != 5'd0) mdl_regs[bus.wb_rd] = bus.wb_data;
    end
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mdl_valid));
    checkOutput("out_flags", 32'({bus.out_memtoreg, bus.out_regwrite, bus.out_memread,
                                  bus.out_memwrite, bus.out_branch, bus.out_jump,
                                  bus.out_jal, bus.out_jr, bus.out_illegal}), 32'(mdl_out.flags));
    checkOutput("out_aluctr", 32'(bus.out_aluctr), 32'(mdl_out.alu));
    checkOutput("out_a", bus.out_a, mdl_out.a);
    checkOutput("out_b", bus.out_b, mdl_out.b);
    checkOutput("out_md", bus.out_md, mdl_out.md);
    checkOutput("out_imm", 32'(bus.out_imm), 32'(mdl_out.imm));
    checkOutput("out_rd", 32'(bus.out_rd), 32'(mdl_out.rd));
    checkOutput("out_pc", bus.out_pc, mdl_out.pc);
    checkOutput("out_jt", bus.out_jt, mdl_out.jt);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [5:0] ops [12];
    logic [5:0] fns [8];
    logic [5:0] op, fn;
    int         k;
    ops = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd2, 6'd3, 6'd63, 6'd0, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd1, 6'd8, 6'd0};
    k  = int'($urandom_range(0, 11));
    op = (k == 11) ? 6'($urandom) : ops[k];
    k  = int'($urandom_range(0, 7));
    fn = (k == 7) ? 6'($urandom) : fns[k];
    if (op == 6'd2 || op == 6'd3) return {op, 26'($urandom)};
    if (op == 6'd0)
      return rtype(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                   5'($urandom_range(0, 31)), fn);
    return itype(op, 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 16'($urandom));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mdl_reset();
    applyStimulus();
    rst = 1'b0;

    $display("[TB] reset state");
    bus.dbg_addr = 5'd29;
    applyStimulus();
    checkOutput("sp_reset", last_dbg, 32'd508);
    bus.dbg_addr = 5'd5;
    applyStimulus();
    checkOutput("r5_reset", last_dbg, 32'd0);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] write-back bypass into add");
    bus.wb_we = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd1;
    applyStimulus();
    bus.in_valid = 1'b1; bus.in_pc = 32'h10; bus.in_ir = rtype(5'd8, 5'd1, 5'd9, 6'd32);
    bus.wb_rd = 5'd8; bus.wb_data = 32'd7;
    applyStimulus();
    bus.wb_we = 1'b0;
    checkOutput("add_a", bus.out_a, 32'd7);
    checkOutput("add_b", bus.out_b, 32'd1);
    checkOutput("add_alu", 32'(bus.out_aluctr), 32'd0);
    checkOutput("add_rd", 32'(bus.out_rd), 32'd9);

    $display("[TB] load-use stall");
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd8; bus.in_ir = rtype(5'd8, 5'd2, 5'd3, 6'd34);
    applyStimulus();
    checkOutput("stall_ready", 32'(last_ready), 32'd0);
    checkOutput("stall_bubble", 32'(bus.out_valid), 32'd0);
    bus.ex_memread = 1'b0;
    applyStimulus();
    checkOutput("sub_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sub_alu", 32'(bus.out_aluctr), 32'd1);

    $display("[TB] backpressure hold");
    bus.out_ready = 1'b0; bus.in_ir = itype(6'd8, 5'd0, 5'd4, 16'd5);
    repeat (3) begin
      applyStimulus();
      checkOutput("hold_ready", 32'(last_ready), 32'd0);
      checkOutput("hold_rd", 32'(bus.out_rd), 32'd3);
    end
    bus.out_ready = 1'b1;
    applyStimulus();
    checkOutput("release_rd", 32'(bus.out_rd), 32'd4);

    $display("[TB] jal and jr");
    bus.in_ir = {6'd3, 26'h40}; bus.in_pc = 32'h104;
    applyStimulus();
    checkOutput("jal_flag", 32'(bus.out_jal), 32'd1);
    checkOutput("jal_rd", 32'(bus.out_rd), 32'd31);
    checkOutput("jal_jt", bus.out_jt, 32'h100);
    checkOutput("jal_a", bus.out_a, 32'h104);
    bus.in_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd31; bus.wb_data = 32'h104;
    applyStimulus();
    bus.wb_we = 1'b0; bus.in_valid = 1'b1; bus.in_ir = rtype(5'd31, 5'd0, 5'd0, 6'd8);
    applyStimulus();
    checkOutput("jr_flag", 32'(bus.out_jr), 32'd1);
    checkOutput("jr_jt", bus.out_jt, 32'h104);

    $display("[TB] flush, r0, illegal");
    bus.in_ir = itype(6'd8, 5'd0, 5'd5, 16'd9); bus.flush = 1'b1;
    applyStimulus();
    bus.flush = 1'b0;
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0; bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'd5;
    bus.dbg_addr = 5'd0;
    applyStimulus();
    checkOutput("r0_bypass", last_dbg, 32'd0);
    bus.wb_we = 1'b0;
    applyStimulus();
    checkOutput("r0_after", last_dbg, 32'd0);
    bus.in_valid = 1'b1; bus.in_ir = {6'd63, 26'd0};
    applyStimulus();
    checkOutput("ill_flag", 32'(bus.out_illegal), 32'd1);
    checkOutput("ill_regwrite", 32'(bus.out_regwrite), 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_pc      = $urandom & 32'hFFFF_FFFC;
      bus.in_ir      = rand_ir();
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.wb_we      = ($urandom_range(0, 1) == 0);
      bus.wb_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
      bus.wb_data    = $urandom;
      bus.ex_memread = ($urandom_range(0, 2) == 0);
      bus.ex_rd      = 5'($urandom_range(0, 9));
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.dbg_addr   = 5'($urandom);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
